ring_decoder: RTL
=================

RING_DECODER -- requirements
Module: ring_decoder

Interface
REQ-001 Parameter WIDTH, default 4: ring width in bits; legal range 2..32.
REQ-002 Parameter LOCK_CNT, default 2: number of consecutive correct rotations needed to lock; legal range 1..15.
REQ-003 Parameter WRAP_W, default 8: width of the wrap counter.
REQ-004 clk  input  1: single clock; all state updates on the rising edge.
REQ-005 rst  input  1: asynchronous, active-low reset.
REQ-006 in_en  input  1: ring_in is sampled only in cycles where in_en=1.
REQ-007 ring_in  input  WIDTH: observed ring-counter value; legal values are one-hot.
REQ-008 err_clr  input  1: clears the ERROR state; used only when the sticky error feature is compiled in.
REQ-009 idx  output  $clog2(WIDTH): binary position of the hot bit in the last accepted sample.
REQ-010 idx_valid  output  1: high while in LOCKED.
REQ-011 locked  output  1: high while state is LOCKED.
REQ-012 seq_err  output  1: one-cycle pulse when a one-hot sample is not rotl(prev).
REQ-013 onehot_err  output  1: one-cycle pulse when a sample has zero or more than one hot bit.
REQ-014 wrap_cnt  output  WRAP_W: count of completed ring revolutions while LOCKED.

Function
REQ-015 Expected step: next = rotl(prev) = {prev[WIDTH-2:0], prev[WIDTH-1]}.
REQ-016 All outputs are registered; the response to a sample at edge N is visible after edge N; latency is 1 cycle.
REQ-017 When in_en=0: state, prev, idx and wrap_cnt hold; error pulses are 0.
REQ-018 States: IDLE, SYNC, LOCKED, ERROR.
REQ-019 IDLE, valid one-hot sample: prev<=sample, good<=0, go to SYNC.
REQ-020 IDLE, non-one-hot sample: pulse onehot_err, stay in IDLE.
REQ-021 SYNC, sample==rotl(prev): good<=good+1, prev<=sample; go to LOCKED when good+1==LOCK_CNT.
REQ-022 SYNC, one-hot sample but wrong step: pulse seq_err, prev<=sample, good<=0, stay in SYNC.
REQ-023 SYNC, non-one-hot sample: pulse onehot_err, go to IDLE.
REQ-024 LOCKED, correct step: update prev and idx.
REQ-025 LOCKED, correct step with idx wrapping WIDTH-1->0: wrap_cnt increments modulo 2^WRAP_W.
REQ-026 LOCKED, wrong step: pulse seq_err, go to ERROR.
REQ-027 LOCKED, non-one-hot sample: pulse onehot_err, go to ERROR.
REQ-028 On leaving LOCKED: idx holds its last value; wrap_cnt holds.
REQ-029 A sample equal to prev (a stalled ring) is a wrong step.
REQ-030 On entering LOCKED from SYNC: wrap_cnt resets to 0.
REQ-031 A sample that is neither one-hot nor the correct step raises onehot_err only; seq_err stays 0.

Reset
REQ-032 rst=0 asynchronously forces: state=IDLE, prev=0, good=0, idx=0, idx_valid=0, locked=0, seq_err=0, onehot_err=0, wrap_cnt=0.
REQ-033 Reset asserted mid-operation, including in LOCKED or ERROR, discards all history; after release the first accepted sample starts a new SYNC.

Configuration
REQ-034 Macro RING_DEC_STICKY_ERR_EN controls ERROR-state behaviour.
REQ-035 Macro defined: ERROR persists and ignores samples until a clock edge with err_clr=1, then goes to IDLE.
REQ-036 Macro defined: a new error and err_clr in the same cycle cannot occur, because ERROR ignores samples.
REQ-037 Macro undefined: ERROR lasts exactly one cycle then goes to IDLE; err_clr is ignored, and the sample presented during the ERROR cycle is ignored.

Verification
REQ-038 WIDTH=4, LOCK_CNT=2, rst low then released, in_en=1, ring 0001,0010,0100 -> locked=1 one cycle after the 0100 sample, idx=2.
REQ-039 Locked ring continues 1000,0001 -> idx goes 3 then 0; wrap_cnt=1 after the 0001 sample.
REQ-040 Locked, then inject 0100 where 0010 is expected -> seq_err pulses once, locked=0; without the macro, state is IDLE two cycles later.
REQ-041 Inject 0110, then 0000 from IDLE -> onehot_err pulses each cycle, state stays IDLE, locked=0.
REQ-042 With RING_DEC_STICKY_ERR_EN: error, then 5 valid samples -> still ERROR; err_clr=1 for one cycle -> IDLE; the valid sequence then relocks.
REQ-043 Assert rst asynchronously mid-LOCKED between edges -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ring_decoder.sv
// ring_decoder: tracks a rotating one-hot ring counter, locks after LOCK_CNT
// consecutive correct rotations, reports the hot-bit position and counts
// completed revolutions while locked.
// Optional build macro RING_DEC_STICKY_ERR_EN: when defined, the ERROR state
// persists until err_clr is seen on a clock edge; otherwise ERROR lasts one
// cycle and err_clr is unused.
module ring_decoder #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 2,
    parameter int WRAP_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_en,
    input  logic [WIDTH-1:0]         ring_in,
    input  logic                     err_clr,
    output logic [$clog2(WIDTH)-1:0] idx,
    output logic                     idx_valid,
    output logic                     locked,
    output logic                     seq_err,
    output logic                     onehot_err,
    output logic [WRAP_W-1:0]        wrap_cnt
);

    localparam int IW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2,
        ERROR  = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] prev;
    logic [3:0]       good;

    logic [WIDTH-1:0] rot;
    logic             sample_onehot;
    logic             step_ok;
    logic [IW-1:0]    sample_idx;
    logic [3:0]       good_next;
    logic             lock_reached;

    // Binary position of the hot bit; only meaningful for one-hot samples.
    function automatic logic [IW-1:0] encode(input logic [WIDTH-1:0] v);
        logic [IW-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) begin
                r = i[IW-1:0];
            end
        end
        return r;
    endfunction

    // Sample classification: one-hot test, expected rotation and step match.
    always_comb begin
        rot           = {prev[WIDTH-2:0], prev[WIDTH-1]};
        sample_onehot = (ring_in != '0) && ((ring_in & (ring_in - 1'b1)) == '0);
        step_ok       = sample_onehot && (ring_in == rot);
        sample_idx    = encode(ring_in);
        good_next     = good + 4'd1;
        lock_reached  = (good_next == 4'(LOCK_CNT));
    end

`ifndef RING_DEC_STICKY_ERR_EN
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
`endif

    // Main state machine; every output is registered here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            prev       <= '0;
            good       <= '0;
            idx        <= '0;
            idx_valid  <= 1'b0;
            locked     <= 1'b0;
            seq_err    <= 1'b0;
            onehot_err <= 1'b0;
            wrap_cnt   <= '0;
        end else begin
            seq_err    <= 1'b0;
            onehot_err <= 1'b0;
            if (state == ERROR) begin
`ifdef RING_DEC_STICKY_ERR_EN
                if (err_clr) begin
                    state <= IDLE;
                end
`else
                state <= IDLE;
`endif
            end else if (in_en) begin
                unique case (state)
                    IDLE: begin
                        if (sample_onehot) begin
                            prev  <= ring_in;
                            idx   <= sample_idx;
                            good  <= '0;
                            state <= SYNC;
                        end else begin
                            onehot_err <= 1'b1;
                        end
                    end
                    SYNC: begin
                        if (!sample_onehot) begin
                            onehot_err <= 1'b1;
                            state      <= IDLE;
                        end else if (step_ok) begin
                            prev <= ring_in;
                            idx  <= sample_idx;
                            good <= good_next;
                            if (lock_reached) begin
                                state     <= LOCKED;
                                locked    <= 1'b1;
                                idx_valid <= 1'b1;
                                wrap_cnt  <= '0;
                            end
                        end else begin
                            seq_err <= 1'b1;
                            prev    <= ring_in;
                            idx     <= sample_idx;
                            good    <= '0;
                        end
                    end
                    LOCKED: begin
                        if (!sample_onehot) begin
                            onehot_err <= 1'b1;
                            state      <= ERROR;
                            locked     <= 1'b0;
                            idx_valid  <= 1'b0;
                        end else if (step_ok) begin
                            prev <= ring_in;
                            idx  <= sample_idx;
                            if (ring_in[0]) begin
                                wrap_cnt <= wrap_cnt + 1'b1;
                            end
                        end else begin
                            seq_err   <= 1'b1;
                            state     <= ERROR;
                            locked    <= 1'b0;
                            idx_valid <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
